// File: rtl/hd44780_ctrl_gen_if.sv
// Host-side request bus of the HD44780 controller: valid/ready request plus status back to the host.
interface hd44780_ctrl_gen_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] op_in;
  logic [7:0] data_in;
  logic       init_done;
  logic       err;
  logic [1:0] cursor_row;
  logic [5:0] cursor_col;

  modport master (
    output req_valid, op_in, data_in,
    input  req_ready, init_done, err, cursor_row, cursor_col
  );

  modport slave (
    input  req_valid, op_in, data_in,
    output req_ready, init_done, err, cursor_row, cursor_col
  );
endinterface

// File: rtl/hd44780_ctrl_gen.sv
// HD44780 character-LCD controller: autonomous power-on init, then host requests with cursor tracking
// and automatic line wrap. Write-only (no busy-flag read); every delay is derived from CLK_HZ.
module hd44780_ctrl_gen #(
  parameter int unsigned CLK_HZ = 20_000_000,
  parameter int unsigned MODE   = 1,
  parameter int unsigned ROWS   = 2,
  parameter int unsigned COLS   = 16
) (
  input  logic                clk,
  input  logic                rst,
  hd44780_ctrl_gen_if.slave   bus,
  output logic                lcd_rs,
  output logic                lcd_rw,
  output logic                lcd_e,
  output logic [7-4*MODE:0]   lcd_data
);

  function automatic int unsigned cyc(input longint unsigned t_ns);
    longint unsigned q;
    q = (t_ns * 64'(CLK_HZ) + 64'd999_999_999) / 64'd1_000_000_000;
    return (q == 64'd0) ? 32'd1 : 32'(q);
  endfunction

  localparam int unsigned T_AS   = cyc(64'd40);
  localparam int unsigned T_PW   = cyc(64'd250);
  localparam int unsigned T_CYC  = cyc(64'd500);
  localparam int unsigned T_EXEC = cyc(64'd42_000);
  localparam int unsigned T_100  = cyc(64'd100_000);
  localparam int unsigned T_CLR  = cyc(64'd1_640_000);
  localparam int unsigned T_41   = cyc(64'd4_100_000);
  localparam int unsigned T_PON  = cyc(64'd15_000_000);
  localparam int unsigned CW     = $clog2(T_PON + 1);
  localparam int unsigned DW     = 8 - 4*MODE;

  // Counter reload values are duration-1 because the exit test is cnt == 0.
  localparam logic [CW-1:0] C_AS   = CW'(T_AS - 1);
  localparam logic [CW-1:0] C_PW   = CW'(T_PW - 1);
  localparam logic [CW-1:0] C_CYC  = CW'(T_CYC - 1);
  localparam logic [CW-1:0] C_EXEC = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] C_100  = CW'(T_100 - 1);
  localparam logic [CW-1:0] C_CLR  = CW'(T_CLR - 1);
  localparam logic [CW-1:0] C_41   = CW'(T_41 - 1);
  localparam logic [CW-1:0] C_PON  = CW'(T_PON - 1);

  localparam bit         NIB      = (MODE != 0);
  localparam logic [2:0] ROWS_L   = 3'(ROWS);
  localparam logic [6:0] COLS_L   = 7'(COLS);
  localparam logic [7:0] FUNC_SET = 8'h20 | (NIB ? 8'h00 : 8'h10) | ((ROWS > 1) ? 8'h08 : 8'h00);
  localparam logic [3:0] INIT_END = 4'd9;

  localparam logic [3:0] PON_WAIT   = 4'd0;
  localparam logic [3:0] INIT_STEP  = 4'd1;
  localparam logic [3:0] IDLE       = 4'd2;
  localparam logic [3:0] XFER_SETUP = 4'd3;
  localparam logic [3:0] XFER_EHIGH = 4'd4;
  localparam logic [3:0] XFER_HOLD  = 4'd5;
  localparam logic [3:0] NIB_GAP    = 4'd6;
  localparam logic [3:0] EXEC_WAIT  = 4'd7;
  localparam logic [3:0] WRAP       = 4'd8;

  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_CLEAR = 3'd1;
  localparam logic [2:0] OP_HOME  = 3'd2;
  localparam logic [2:0] OP_SETC  = 3'd3;
  localparam logic [2:0] OP_RAW   = 3'd4;

  function automatic logic [6:0] ddram_addr(input logic [1:0] r, input logic [5:0] c);
    logic [6:0] base;
    case (r)
      2'd0:    base = 7'h00;
      2'd1:    base = 7'h40;
      2'd2:    base = 7'(COLS);
      default: base = 7'(64 + COLS);
    endcase
    return base + {1'b0, c};
  endfunction

  // In 4-bit mode the panel's D7..D4 carry the nibble, so the selected nibble sits in the top bits.
  function automatic logic [DW-1:0] bus_slice(input logic [7:0] b, input logic low);
    logic [7:0] s;
    s = low ? {b[3:0], 4'h0} : b;
    return s[7 -: DW];
  endfunction

  logic [3:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    step;
  logic [7:0]    xbyte;
  logic          xlow;
  logic          xsingle;
  logic [CW-1:0] xexec;
  logic          wrap_pend;
  logic          ready_q;
  logic          done_q;
  logic          err_q;
  logic [1:0]    row_q;
  logic [5:0]    col_q;

  logic          launch;
  logic [7:0]    l_byte;
  logic          l_rs;
  logic          l_single;
  logic [CW-1:0] l_exec;
  logic          bad_req;
  logic          upd_cur;
  logic          set_wrap;
  logic [1:0]    nxt_row;
  logic [5:0]    nxt_col;
  logic [6:0]    inc_col;
  logic [1:0]    sc_row;
  logic [5:0]    sc_col;

  assign sc_row  = bus.data_in[7:6];
  assign sc_col  = bus.data_in[5:0];
  assign inc_col = {1'b0, col_q} + 7'd1;

  always_comb begin
    launch   = 1'b0;
    l_byte   = 8'h00;
    l_rs     = 1'b0;
    l_single = 1'b0;
    l_exec   = C_EXEC;
    bad_req  = 1'b0;
    upd_cur  = 1'b0;
    set_wrap = 1'b0;
    nxt_row  = row_q;
    nxt_col  = col_q;
    case (state)
      INIT_STEP: begin
        launch = 1'b1;
        case (step)
          4'd0:    begin l_byte = 8'h30; l_single = 1'b1; l_exec = C_41;  end
          4'd1:    begin l_byte = 8'h30; l_single = 1'b1; l_exec = C_100; end
          4'd2:    begin l_byte = 8'h30; l_single = 1'b1; end
          4'd3:    begin l_byte = 8'h20; l_single = 1'b1; end
          4'd4:    l_byte = FUNC_SET;
          4'd5:    l_byte = 8'h08;
          4'd6:    begin l_byte = 8'h01; l_exec = C_CLR; end
          4'd7:    l_byte = 8'h06;
          default: l_byte = 8'h0C;
        endcase
      end
      WRAP: begin
        launch = 1'b1;
        l_byte = {1'b1, ddram_addr(row_q, 6'd0)};
      end
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          case (bus.op_in)
            OP_WRITE: begin
              launch  = 1'b1;
              l_rs    = 1'b1;
              l_byte  = bus.data_in;
              upd_cur = 1'b1;
              if (inc_col == COLS_L) begin
                nxt_col  = 6'd0;
                nxt_row  = (({1'b0, row_q} + 3'd1) == ROWS_L) ? 2'd0 : row_q + 2'd1;
                set_wrap = 1'b1;
              end else begin
                nxt_col = inc_col[5:0];
              end
            end
            OP_CLEAR, OP_HOME: begin
              launch  = 1'b1;
              l_byte  = (bus.op_in == OP_CLEAR) ? 8'h01 : 8'h02;
              l_exec  = C_CLR;
              upd_cur = 1'b1;
              nxt_row = 2'd0;
              nxt_col = 6'd0;
            end
            OP_SETC: begin
              if (({1'b0, sc_row} >= ROWS_L) || ({1'b0, sc_col} >= COLS_L)) begin
                bad_req = 1'b1;
              end else begin
                launch  = 1'b1;
                l_byte  = {1'b1, ddram_addr(sc_row, sc_col)};
                upd_cur = 1'b1;
                nxt_row = sc_row;
                nxt_col = sc_col;
              end
            end
            OP_RAW: begin
              launch = 1'b1;
              l_byte = bus.data_in;
              // Clear and return-home encodings need the long execution time.
              l_exec = ((bus.data_in[7:2] == 6'd0) && (bus.data_in != 8'd0)) ? C_CLR : C_EXEC;
            end
            default: bad_req = 1'b1;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PON_WAIT;
      cnt       <= C_PON;
      step      <= 4'd0;
      xbyte     <= 8'h00;
      xlow      <= 1'b0;
      xsingle   <= 1'b0;
      xexec     <= C_EXEC;
      wrap_pend <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      row_q     <= 2'd0;
      col_q     <= 6'd0;
      lcd_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_data  <= '0;
    end else begin
      err_q <= 1'b0;
      if (launch) begin
        xbyte    <= l_byte;
        xlow     <= 1'b0;
        xsingle  <= l_single;
        xexec    <= l_exec;
        lcd_rs   <= l_rs;
        lcd_data <= bus_slice(l_byte, 1'b0);
        cnt      <= C_AS;
        ready_q  <= 1'b0;
        state    <= XFER_SETUP;
      end
      case (state)
        PON_WAIT: begin
          if (cnt == '0) state <= INIT_STEP;
          else           cnt   <= cnt - 1'b1;
        end
        INIT_STEP: step <= (step == 4'd2 && !NIB) ? 4'd4 : step + 4'd1;
        IDLE: begin
          if (bad_req)  err_q     <= 1'b1;
          if (set_wrap) wrap_pend <= 1'b1;
          if (upd_cur) begin
            row_q <= nxt_row;
            col_q <= nxt_col;
          end
        end
        WRAP: wrap_pend <= 1'b0;
        XFER_SETUP: begin
          if (cnt == '0) begin
            lcd_e <= 1'b1;
            cnt   <= C_PW;
            state <= XFER_EHIGH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        XFER_EHIGH: begin
          if (cnt == '0) begin
            lcd_e <= 1'b0;
            state <= XFER_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        XFER_HOLD: begin
          if (NIB && !xsingle && !xlow) begin
            cnt   <= C_CYC;
            state <= NIB_GAP;
          end else begin
            cnt   <= xexec;
            state <= EXEC_WAIT;
          end
        end
        NIB_GAP: begin
          if (cnt == '0) begin
            xlow     <= 1'b1;
            lcd_data <= bus_slice(xbyte, 1'b1);
            cnt      <= C_AS;
            state    <= XFER_SETUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        EXEC_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!done_q) begin
            if (step == INIT_END) begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              state   <= IDLE;
            end else begin
              state <= INIT_STEP;
            end
          end else if (wrap_pend) begin
            state <= WRAP;
          end else begin
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= PON_WAIT;
      endcase
    end
  end

  assign lcd_rw         = 1'b0;
  assign bus.req_ready  = ready_q;
  assign bus.init_done  = done_q;
  assign bus.err        = err_q;
  assign bus.cursor_row = row_q;
  assign bus.cursor_col = col_q;

endmodule

// File: tb/tb_hd44780_ctrl_gen.sv
// Directed bench: a 4-bit/2x16 controller exercised through init, writes, wrap, cursor, clear, raw and
// reset; an 8-bit instance on the same clock and reset is checked for its init byte sequence.
module tb_hd44780_ctrl_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hd44780_ctrl_gen_if ia ();
  hd44780_ctrl_gen_if ib ();

  logic       rs_a, rw_a, e_a;
  logic [3:0] d_a;
  logic       rs_b, rw_b, e_b;
  logic [7:0] d_b;

  hd44780_ctrl_gen #(.CLK_HZ(1_000_000), .MODE(1), .ROWS(2), .COLS(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ia),
    .lcd_rs(rs_a), .lcd_rw(rw_a), .lcd_e(e_a), .lcd_data(d_a)
  );

  hd44780_ctrl_gen #(.CLK_HZ(1_000_000), .MODE(0), .ROWS(2), .COLS(16)) dut_b (
    .clk(clk), .rst(rst), .bus(ib),
    .lcd_rs(rs_b), .lcd_rw(rw_b), .lcd_e(e_b), .lcd_data(d_b)
  );

  logic [3:0] exp_a [14] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC};
  logic [7:0] exp_b [8]  = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

  // Monitor: logs every E rising edge with {rs, data} and time-stamps edges of interest.
  int         cyc = 0, na = 0, nb = 0;
  int         fall_cyc = 0, rdy_cyc = 0, done_cyc = 0, err_cnt = 0;
  logic       pe_a = 1'b0, pe_b = 1'b0, pr_a = 1'b0, pd_a = 1'b0;
  logic [4:0] log_a [1024];
  logic [8:0] log_b [64];

  always @(negedge clk) begin
    cyc  <= cyc + 1;
    pe_a <= e_a;
    pe_b <= e_b;
    pr_a <= ia.req_ready;
    pd_a <= ia.init_done;
    if (e_a && !pe_a && na < 1024) begin
      log_a[na] <= {rs_a, d_a};
      na        <= na + 1;
    end
    if (e_b && !pe_b && nb < 64) begin
      log_b[nb] <= {rs_b, d_b};
      nb        <= nb + 1;
    end
    if (!e_a && pe_a)                fall_cyc <= cyc;
    if (ia.req_ready && !pr_a)       rdy_cyc  <= cyc;
    if (ia.init_done && !pd_a)       done_cyc <= cyc;
    if (ia.err)                      err_cnt  <= err_cnt + 1;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget, input string tag);
    for (int i = 0; i < budget && !ia.req_ready; i++) tick();
    if (!ia.req_ready) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget && !ia.init_done; i++) tick();
    if (!ia.init_done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] d);
    ia.op_in     = op;
    ia.data_in   = d;
    ia.req_valid = 1'b1;
    tick();
    ia.req_valid = 1'b0;
  endtask

  task automatic check_cmd(input string tag, input int base, input logic rs, input logic [7:0] b);
    check({tag, "_hi"}, 32'(log_a[base]),     32'({rs, b[7:4]}));
    check({tag, "_lo"}, 32'(log_a[base + 1]), 32'({rs, b[3:0]}));
  endtask

  task automatic check_init_a(input string tag, input int base);
    check({tag, "_count"}, 32'(na - base), 32'd14);
    for (int i = 0; i < 14; i++) check({tag, "_nib"}, 32'(log_a[base + i]), 32'({1'b0, exp_a[i]}));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_e"},     32'(e_a),           32'd0);
    check({tag, "_rs"},    32'(rs_a),          32'd0);
    check({tag, "_rw"},    32'(rw_a),          32'd0);
    check({tag, "_data"},  32'(d_a),           32'd0);
    check({tag, "_ready"}, 32'(ia.req_ready),  32'd0);
    check({tag, "_done"},  32'(ia.init_done),  32'd0);
    check({tag, "_err"},   32'(ia.err),        32'd0);
    check({tag, "_row"},   32'(ia.cursor_row), 32'd0);
    check({tag, "_col"},   32'(ia.cursor_col), 32'd0);
    check({tag, "_e_b"},   32'(e_b),           32'd0);
  endtask

  initial begin
    int base, e0, w;
    rst          = 1'b0;
    ia.req_valid = 1'b0;
    ia.op_in     = 3'd0;
    ia.data_in   = 8'h00;
    ib.req_valid = 1'b0;
    ib.op_in     = 3'd0;
    ib.data_in   = 8'h00;
    repeat (3) tick();
    check_reset_outputs("reset");

    // Power-on wait and init sequence
    rst = 1'b1;
    w = 0;
    while (!e_a && w < 16000) begin tick(); w++; end
    check("pon_first_e_seen", 32'(e_a), 32'd1);
    check("pon_gap_ge_15000", 32'(w >= 15000), 32'd1);
    wait_done(30000, "init_a");
    check_init_a("init_a", 0);
    check("init_ready_with_done", 32'(ia.req_ready), 32'd1);
    check("init_done_ready_same_cycle", 32'(done_cyc), 32'(rdy_cyc));
    check("init_final_wait", 32'(done_cyc - fall_cyc), 32'd43);
    for (int i = 0; i < 100 && !ib.init_done; i++) tick();
    check("init_b_done", 32'(ib.init_done), 32'd1);
    check("init_b_count", 32'(nb), 32'd8);
    for (int i = 0; i < 8; i++) check("init_b_byte", 32'(log_b[i]), 32'({1'b0, exp_b[i]}));

    // WRITE 'A'
    base = na;
    send(3'd0, 8'h41);
    wait_ready(200, "write41");
    check("write41_count", 32'(na - base), 32'd2);
    check_cmd("write41", base, 1'b1, 8'h41);
    check("write41_latency", 32'(rdy_cyc - fall_cyc), 32'd43);
    check("write41_col", 32'(ia.cursor_col), 32'd1);
    check("write41_row", 32'(ia.cursor_row), 32'd0);

    // CLEAR
    base = na;
    send(3'd1, 8'h00);
    wait_ready(2000, "clear");
    check_cmd("clear", base, 1'b0, 8'h01);
    check("clear_latency", 32'(rdy_cyc - fall_cyc), 32'd1641);
    check("clear_row", 32'(ia.cursor_row), 32'd0);
    check("clear_col", 32'(ia.cursor_col), 32'd0);

    // 16 writes wrap to row 1, 16 more wrap back to row 0
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 16; k++) begin
        base = na;
        send(3'd0, 8'h30 + 8'(k));
        wait_ready(300, "fill");
      end
      check("wrap_count", 32'(na - base), 32'd4);
      check_cmd("wrap_cmd", base + 2, 1'b0, (pass == 0) ? 8'hC0 : 8'h80);
      check("wrap_row", 32'(ia.cursor_row), (pass == 0) ? 32'd1 : 32'd0);
      check("wrap_col", 32'(ia.cursor_col), 32'd0);
      check("wrap_latency", 32'(rdy_cyc - fall_cyc), 32'd43);
    end

    // SET_CURSOR legal and out of range, illegal op
    base = na;
    send(3'd3, 8'h45);
    wait_ready(200, "setc45");
    check_cmd("setc45", base, 1'b0, 8'hC5);
    check("setc45_row", 32'(ia.cursor_row), 32'd1);
    check("setc45_col", 32'(ia.cursor_col), 32'd5);

    base = na;
    e0 = err_cnt;
    send(3'd3, 8'h85);
    repeat (4) tick();
    check("setc85_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("setc85_no_e", 32'(na - base), 32'd0);
    check("setc85_ready", 32'(ia.req_ready), 32'd1);
    check("setc85_row", 32'(ia.cursor_row), 32'd1);
    check("setc85_col", 32'(ia.cursor_col), 32'd5);

    base = na;
    e0 = err_cnt;
    send(3'd7, 8'h00);
    repeat (4) tick();
    check("op7_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("op7_no_e", 32'(na - base), 32'd0);

    // HOME, then position cursor for the raw-command checks
    base = na;
    send(3'd2, 8'h00);
    wait_ready(2000, "home");
    check_cmd("home", base, 1'b0, 8'h02);
    check("home_latency", 32'(rdy_cyc - fall_cyc), 32'd1641);
    check("home_row", 32'(ia.cursor_row), 32'd0);
    check("home_col", 32'(ia.cursor_col), 32'd0);
    send(3'd3, 8'h43);
    wait_ready(200, "setc43");

    // RAW_CMD short exec, with an illegal request attempted while busy
    base = na;
    e0 = err_cnt;
    send(3'd4, 8'h0F);
    send(3'd7, 8'h00);
    wait_ready(200, "raw0f");
    check_cmd("raw0f", base, 1'b0, 8'h0F);
    check("raw0f_latency", 32'(rdy_cyc - fall_cyc), 32'd43);
    check("busy_req_no_err", 32'(err_cnt - e0), 32'd0);
    check("raw0f_row", 32'(ia.cursor_row), 32'd1);
    check("raw0f_col", 32'(ia.cursor_col), 32'd3);

    base = na;
    send(3'd4, 8'h02);
    wait_ready(2000, "raw02");
    check_cmd("raw02", base, 1'b0, 8'h02);
    check("raw02_latency", 32'(rdy_cyc - fall_cyc), 32'd1641);
    check("raw02_col", 32'(ia.cursor_col), 32'd3);

    // Reset while E is high
    send(3'd0, 8'h55);
    for (int i = 0; i < 20 && !e_a; i++) tick();
    check("midreset_e_high", 32'(e_a), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) tick();
    base = na;
    rst = 1'b1;
    wait_done(30000, "reinit");
    check_init_a("reinit", base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hd44780_ctrl_gen.md
Name: hd44780_ctrl_gen

Overview:
- Second-generation character-LCD controller for HD44780-compatible panels (1602A and larger).
- Fully parametrised: clock frequency (all delays derived at elaboration), 4/8-bit bus, 1–4 rows, 8–40 columns.
- Runs the power-on init sequence autonomously, then accepts high-level requests over a valid/ready handshake.
- Tracks the cursor and auto-wraps lines. Sits between a host FSM/UART bridge and the LCD pins; write-only, no busy-flag read.

Parameters:
- CLK_HZ, 20_000_000, clock frequency in Hz; all delay counts derived from it.
- MODE, 1, 0 = 8-bit bus, 1 = 4-bit bus.
- ROWS, 2, display rows, 1..4.
- COLS, 16, display columns, 8..40.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  controller can accept a request.
- op_in  in  3  0 WRITE, 1 CLEAR, 2 HOME, 3 SET_CURSOR, 4 RAW_CMD; 5–7 illegal.
- data_in  in  8  char (WRITE), command (RAW_CMD), {row[7:6], col[5:0]} (SET_CURSOR).
- init_done  out  1  init sequence complete (sticky until reset).
- err  out  1  one-cycle pulse on a rejected request.
- cursor_row  out  2  tracked row.
- cursor_col  out  6  tracked column.
- lcd_rs  out  1  register select.
- lcd_rw  out  1  tied 0.
- lcd_e  out  1  enable strobe.
- lcd_data  out  8-4*MODE  LCD data bus.

Behaviour:
- Delay function: cyc(t) = max(1, ceil(t_ns*CLK_HZ/1e9)), computed with 64-bit elaboration math.
  - Timing constants: T_AS = cyc(40ns), T_PW = cyc(250ns), T_CYC = cyc(500ns), T_EXEC = cyc(42us), T_100 = cyc(100us), T_CLR = cyc(1.64ms), T_41 = cyc(4.1ms), T_PON = cyc(15ms).
  - Single shared down-counter, width $clog2(T_PON+1).
- Reset values (rst low, asynchronous): lcd_e = 0, lcd_rs = 0, lcd_rw = 0, lcd_data = 0, req_ready = 0, init_done = 0, err = 0, cursor = 0,0. FSM goes to PON_WAIT.
- Transfer micro-sequence, one E cycle per nibble/byte:
  - Drive rs/data, E low for T_AS cycles.
  - E high for T_PW cycles.
  - E low for 1 cycle with data held.
  - 4-bit mode: high nibble first, then T_CYC cycles idle, then low nibble.
  - After the last E fall, wait the command's exec time.
  - rs and data stay stable throughout.
- Init sequence, no host interaction:
  - Wait T_PON.
  - Single-nibble/byte 0x3 (8-bit: 0x30), wait T_41.
  - 0x3, wait T_100.
  - 0x3, wait T_EXEC.
  - 4-bit only: nibble 0x2, wait T_EXEC.
  - Full commands: function set 0x20|(!MODE)<<4|(ROWS>1)<<3, display off 0x08, clear 0x01 (T_CLR), entry mode 0x06, display on 0x0C. Each is followed by T_EXEC unless stated.
  - Then init_done = 1 and the FSM goes to IDLE.
- FSM states: PON_WAIT, INIT_STEP, IDLE, XFER_SETUP, XFER_EHIGH, XFER_HOLD, NIB_GAP, EXEC_WAIT, WRAP.
- Handshake:
  - req_ready = 1 only in IDLE.
  - A request is accepted on the rising edge with req_valid & req_ready.
  - req_ready drops the next cycle and rises again on the cycle after the exec wait expires.
  - op_in and data_in are sampled only at acceptance.
- Op rules:
  - WRITE: rs = 1, data_in, exec T_EXEC, col+1.
    - If the new col == COLS: col = 0, row = (row+1) mod ROWS.
    - WRAP then issues set-DDRAM 0x80|addr(row,0) (rs = 0, T_EXEC) before returning to IDLE.
  - CLEAR (0x01) / HOME (0x02): exec T_CLR; cursor = 0,0.
  - SET_CURSOR: if row >= ROWS or col >= COLS, err pulses, there is no LCD activity, the cursor is unchanged and req_ready stays 1. Otherwise the command is 0x80|addr and the cursor is updated.
    - addr(r,c) = {0x00, 0x40, COLS, 0x40+COLS}[r] + c.
  - RAW_CMD: data_in sent rs = 0. Exec is T_CLR if data_in[7:2] == 0 and data_in != 0, else T_EXEC. The cursor is not updated.
  - op 5–7: err pulse, ignored.
- Requests while req_ready = 0 are ignored, with no err.
- Reset asserted mid-transfer: lcd_e drops in the same instant (asynchronous) and init restarts from PON_WAIT after release.

Test Plan:
- CLK_HZ = 1_000_000, MODE = 1, ROWS = 2, COLS = 16; release reset:
  - lcd_e stays 0 for ≥ 15000 cycles.
  - E-pulse nibbles are exactly 3,3,3,2,2,8,0,8,0,1,0,6,0,C, all with rs = 0.
  - init_done and req_ready rise together after the final 42-cycle wait.
- WRITE 0x41:
  - Nibbles 4 then 1 with rs = 1; each E high ≥ 1 cycle.
  - req_ready returns 42+1 cycles after the final E fall; cursor_col = 1.
- 16 WRITEs from 0,0:
  - After the 16th, command 0xC0 is emitted (nibbles C,0) and the cursor is 1,0.
  - 16 more WRITEs produce 0x80 and the cursor is 0,0.
- SET_CURSOR 0x45 (row 1, col 5): command 0xC5 is emitted.
  - SET_CURSOR 0x85 (row 2): err high exactly 1 cycle, no E pulse, cursor unchanged.
  - op = 7: err pulse.
- CLEAR: command 0x01 is emitted, req_ready returns 1640+1 cycles after E fall, cursor = 0,0.
  - RAW_CMD 0x0F waits 42; RAW_CMD 0x02 waits 1640.
- Reset mid-transfer:
  - Pull rst low while lcd_e = 1: lcd_e = 0 immediately and all outputs are at reset values. After release, the full init restarts.
  - Repeat the bench with MODE = 0: 8-bit bus, init bytes 0x30 ×3 then 0x38, and no 0x2 step.
